lut_neuron_rt: RTL
==================

# lut_neuron_rt

Runtime-programmable, pipelined successor to the generated fixed-ROM LUT neurons in the LogicNets layers. It holds CHANNELS truth tables of 2^IN_BITS entries × OUT_BITS, all addressed by one shared input word. Tables are written through a configuration port instead of being baked in at generation time. Lookups stream through a 2-stage valid/ready pipeline, and hardware clears all tables after reset or on request.

## Interface
- IN_BITS, 8, input word width = table address width
- OUT_BITS, 2, output width per channel
- CHANNELS, 4, number of independent tables sharing the input word
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_data  in  IN_BITS  lookup address
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts in_data this cycle
- out_data  out  CHANNELS*OUT_BITS  channel c at bits [c*OUT_BITS +: OUT_BITS]
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- cfg_we  in  1  table write strobe
- cfg_sel  in  $clog2(CHANNELS) (min 1)  channel to write
- cfg_addr  in  IN_BITS  entry to write
- cfg_data  in  OUT_BITS  entry value
- cfg_clr  in  1  request full clear of all tables
- busy  out  1  high in CLEAR or DRAIN

## Operation
- Tables are distributed RAM, not reset. Contents are defined only by the clear sweep and cfg writes.
- FSM states: CLEAR, RUN, DRAIN.
  - Reset enters CLEAR with clr_cnt=0.
  - CLEAR: each cycle writes 0 to entry clr_cnt of every channel, then clr_cnt++. After writing entry 2^IN_BITS-1 → RUN. Takes exactly 2^IN_BITS cycles. clr_cnt is IN_BITS+1 wide, so it does not wrap.
  - RUN: cfg_clr=1 → DRAIN.
  - DRAIN: in_ready=0. Once stage 1 is empty → CLEAR with clr_cnt=0. Stage 2 may still hold data and keeps its value.
- cfg_we is honoured only in RUN; it is ignored in CLEAR and DRAIN. If cfg_clr and cfg_we are both high in RUN, the write takes effect and DRAIN is still entered.
- cfg_sel ≥ CHANNELS: write is ignored.
- Pipeline:
  - Stage 1 registers in_data (addr1, v1).
  - Stage 2 registers the combinational lookup of all channels at addr1 (out_data, out_valid).
  - Stage k advances when its successor is empty or being consumed: s2_ready = !out_valid | out_ready; s1_ready = !v1 | s2_ready.
  - in_ready = (state==RUN) & s1_ready.
- A cfg write to the entry being read in the same cycle is read-before-write: stage 2 captures the old value, and the new value is visible from the next cycle.
- Table read index is exactly in_data (bit 0 = LSB); no reordering.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, busy=1, v1=0, state=CLEAR, clr_cnt=0.
- First in_ready=1 is 2^IN_BITS cycles after rst deasserts.
- Latency: transfer in cycle t → out_valid=1 in cycle t+2 if unstalled.
- Throughput is 1 word/cycle with out_ready held high.
- Backpressure:
  - With out_ready=0, out_data and out_valid hold stable.
  - Stage 1 keeps 1 more word, then in_ready=0.
  - No word is lost or duplicated.
- busy rises the cycle after cfg_clr is sampled in RUN, and falls in the cycle RUN is re-entered.
- rst asserted mid-operation clears pipeline valids immediately (async) and restarts CLEAR. In-flight words are discarded.

## Test plan
- Reset then idle: out_valid=0 and busy=1 for 256 cycles; in_ready=1 on cycle 256; a lookup of 0xA5 returns out_data=0 on all channels.
- Program ch0[0x40]=2'b11, ch3[0x40]=2'b01, then send 0x40 → out_data=8'b01_00_00_11 two cycles after transfer.
- Streaming: program ch1[i]=i[1:0] for all i, send 0..255 back-to-back with out_ready=1 → 256 outputs in order; ch1 field of output n equals n mod 4; no bubbles.
- Backpressure: random out_ready (50%) during the 256-word stream → same ordered output; out_data stable while out_valid & !out_ready.
- Same-cycle hazard: ch2[0x11]=1, then write ch2[0x11]=3 in the same cycle 0x11 sits in stage 1 → that output shows 1; the next lookup of 0x11 shows 3.
- cfg_clr with stage 1 full and out_ready=0 → in_ready=0, the held output survives, then 256 clear cycles; later lookups of programmed addresses return 0; cfg_we during CLEAR has no effect.

Source files
------------

// File: rtl/lut_neuron_rt.sv
// lut_neuron_rt: runtime-programmable bank of CHANNELS truth tables
// (2^IN_BITS entries x OUT_BITS each) addressed by one shared input word.
// Lookups flow through a 2-stage valid/ready pipeline. Tables are cleared by
// a hardware sweep after reset or on cfg_clr.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_data/valid/ready    lookup address stream (upstream handshake)
//   out_data/valid/ready   per-channel results, channel c at [c*OUT_BITS +: OUT_BITS]
//   cfg_we/sel/addr/data   single-entry table write (honoured in RUN only)
//   cfg_clr           request a full clear of all tables
//   busy              high while draining or clearing
module lut_neuron_rt #(
  parameter int unsigned IN_BITS  = 8,
  parameter int unsigned OUT_BITS = 2,
  parameter int unsigned CHANNELS = 4,
  localparam int unsigned SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [IN_BITS-1:0]           in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [CHANNELS*OUT_BITS-1:0] out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  input  logic                         cfg_we,
  input  logic [SEL_W-1:0]             cfg_sel,
  input  logic [IN_BITS-1:0]           cfg_addr,
  input  logic [OUT_BITS-1:0]          cfg_data,
  input  logic                         cfg_clr,
  output logic                         busy
);

  localparam int unsigned DEPTH = 1 << IN_BITS;
  localparam int unsigned CNT_W = IN_BITS + 1;
  localparam int unsigned OUT_W = CHANNELS * OUT_BITS;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_clr_cnt;
  logic                r_v1;
  logic [IN_BITS-1:0]  r_addr1;
  logic                r_out_valid;
  logic [OUT_W-1:0]    r_out_data;

  // Tables hold no reset: contents come only from the clear sweep and cfg writes.
  logic [OUT_BITS-1:0] r_mem [CHANNELS][DEPTH];

  logic                w_s2_ready;
  logic                w_s1_ready;
  logic                w_in_ready;
  logic                w_in_fire;
  logic                w_sel_ok;
  logic                w_cfg_wr;
  logic [IN_BITS-1:0]  w_clr_addr;
  logic [OUT_W-1:0]    w_lookup;

  // Handshake: a stage advances when its successor is empty or being consumed.
  assign w_s2_ready = !r_out_valid || out_ready;
  assign w_s1_ready = !r_v1 || w_s2_ready;
  assign w_in_ready = (r_state == S_RUN) && w_s1_ready;
  assign w_in_fire  = in_valid && w_in_ready;
  assign w_clr_addr = r_clr_cnt[IN_BITS-1:0];

  // Out-of-range channel selects are dropped; unreachable when CHANNELS fills the select width.
  if ((1 << SEL_W) == CHANNELS) begin : g_sel_full
    assign w_sel_ok = 1'b1;
  end else begin : g_sel_part
    assign w_sel_ok = (32'(cfg_sel) < CHANNELS);
  end

  assign w_cfg_wr = (r_state == S_RUN) && cfg_we && w_sel_ok;

  // Combinational read of every channel at the stage-1 address.
  always_comb begin
    w_lookup = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_lookup[c*OUT_BITS +: OUT_BITS] = r_mem[c][r_addr1];
    end
  end

  // Table write port: clear sweep has priority; reads in the same cycle see old data.
  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (r_state == S_CLEAR) begin
        r_mem[c][w_clr_addr] <= '0;
      end else if (w_cfg_wr && (cfg_sel == SEL_W'(c))) begin
        r_mem[c][cfg_addr] <= cfg_data;
      end
    end
  end

  // Control FSM and pipeline registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_CLEAR;
      r_clr_cnt   <= '0;
      r_v1        <= 1'b0;
      r_addr1     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      unique case (r_state)
        S_CLEAR: begin
          r_clr_cnt <= r_clr_cnt + CNT_W'(1);
          if (r_clr_cnt == CNT_W'(DEPTH - 1)) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (cfg_clr) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Only stage 1 must empty; stage 2 keeps its word across the clear.
          if (!r_v1) begin
            r_state   <= S_CLEAR;
            r_clr_cnt <= '0;
          end
        end
        default: begin
          r_state   <= S_CLEAR;
          r_clr_cnt <= '0;
        end
      endcase

      if (w_s1_ready) begin
        r_v1 <= w_in_fire;
        if (w_in_fire) begin
          r_addr1 <= in_data;
        end
      end

      if (w_s2_ready) begin
        r_out_valid <= r_v1;
        if (r_v1) begin
          r_out_data <= w_lookup;
        end
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = (r_state != S_RUN);

endmodule
